// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } md_state_t;

    localparam int REG_AW_DEF = 5;
    localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/md_seq_fsm.sv
// Mul/div sequencer: launches the unit, holds E until MD_Done, and latches
// a sticky timeout error if MD_Done never arrives.
module md_seq_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic MulDivE,
    input  logic PCSrcE,
    input  logic MD_Done,
    output logic md_hold,
    output logic MD_Start,
    output logic MD_Busy,
    output logic MD_TimeoutErr
);

    localparam int CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

    md_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        md_hold       = 1'b0;
        MD_Start      = 1'b0;
        MD_Busy       = 1'b0;
        MD_TimeoutErr = 1'b0;
        case (state)
            IDLE: begin
                // A taken branch kills the mul/div sitting in E, so no launch.
                if (MulDivE && !PCSrcE) begin
                    MD_Start  = 1'b1;
                    md_hold   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                MD_Busy = 1'b1;
                if (MD_Done) begin
                    state_nxt = IDLE;
                end else begin
                    md_hold = 1'b1;
                    if (cnt == CNT_LAST) state_nxt = ERR;
                    else                 cnt_nxt   = cnt + 1'b1;
                end
            end
            ERR: begin
                md_hold       = 1'b1;
                MD_TimeoutErr = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            md_hold       = 1'b0;
            MD_Start      = 1'b0;
            MD_Busy       = 1'b0;
            MD_TimeoutErr = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush generation for the 5-stage pipeline: load-use bubbles, taken
// branch flushes and multi-cycle mul/div holds in E.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int REG_AW     = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] RD_E,
    input  logic              RegWriteE,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MulDivE,
    input  logic              MD_Done,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MD_Start,
    output logic              MD_Busy,
    output logic              MD_TimeoutErr
);

    logic lw_stall;
    logic md_hold;

    assign lw_stall = ResultSrcE0 & RegWriteE & (RD_E != REG_AW'(X0)) &
                      ((RD_E == Rs1_D) | (RD_E == Rs2_D));

    md_seq_fsm #(
        .MD_TIMEOUT(MD_TIMEOUT)
    ) u_md_seq (
        .clk          (clk),
        .rst          (rst),
        .MulDivE      (MulDivE),
        .PCSrcE       (PCSrcE),
        .MD_Done      (MD_Done),
        .md_hold      (md_hold),
        .MD_Start     (MD_Start),
        .MD_Busy      (MD_Busy),
        .MD_TimeoutErr(MD_TimeoutErr)
    );

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (rst) begin
            // all outputs held low
        end else if (md_hold || MD_Busy) begin
            // Sequencer owns the pipe: D/E flushes are suppressed, even on the
            // MD_Done cycle when the stalls themselves have already dropped.
            StallF = md_hold;
            StallD = md_hold;
            StallE = md_hold;
            FlushM = md_hold;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized and directed bench for pipeline_stall_controller, checked
// against a rule-level reference model for two timeout settings.
module tb_pipeline_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, RD_E;
    logic       RegWriteE, ResultSrcE0, PCSrcE, MulDivE, MD_Done;

    logic sf_a, sd_a, se_a, fd_a, fe_a, fm_a, st_a, bz_a, er_a;
    logic sf_b, sd_b, se_b, fd_b, fe_b, fm_b, st_b, bz_b, er_b;

    int total = 0;
    int bad   = 0;

    // model state per instance: mode 0=idle 1=waiting on mul/div 2=timed out
    int mode_a, cnt_a, mode_b, cnt_b;

    always #5 clk = ~clk;

    pipeline_stall_controller dut_a (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MulDivE(MulDivE), .MD_Done(MD_Done),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .FlushD(fd_a),
        .FlushE(fe_a), .FlushM(fm_a), .MD_Start(st_a), .MD_Busy(bz_a),
        .MD_TimeoutErr(er_a)
    );

    pipeline_stall_controller #(
        .MD_TIMEOUT(4)
    ) dut_b (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MulDivE(MulDivE), .MD_Done(MD_Done),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .FlushD(fd_b),
        .FlushE(fe_b), .FlushM(fm_b), .MD_Start(st_b), .MD_Busy(bz_b),
        .MD_TimeoutErr(er_b)
    );

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (StallF,StallD,StallE,FlushD,FlushE,FlushM,Start,Busy,Err)",
                     tag, got, exp);
        end
    endtask

    // Expected {StallF,StallD,StallE,FlushD,FlushE,FlushM,MD_Start,MD_Busy,MD_TimeoutErr}
    function automatic logic [8:0] expect_out(input int mode);
        logic hazard;
        logic [8:0] r;
        r = '0;
        hazard = ResultSrcE0 && RegWriteE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
        if (rst) return '0;
        if (mode == 0) begin
            if (MulDivE && !PCSrcE) r = 9'b111_001_100;
            else r = {hazard, hazard, 1'b0, PCSrcE, hazard || PCSrcE, 4'b0000};
        end else if (mode == 1) begin
            r = MD_Done ? 9'b000_000_010 : 9'b111_001_010;
        end else begin
            r = 9'b111_001_001;
        end
        return r;
    endfunction

    task automatic advance(inout int mode, inout int cnt, input int tmo);
        if (rst) begin
            mode = 0; cnt = 0;
        end else if (mode == 0) begin
            if (MulDivE && !PCSrcE) begin mode = 1; cnt = 0; end
        end else if (mode == 1) begin
            if (MD_Done)              mode = 0;
            else if (cnt + 1 >= tmo)  mode = 2;
            else                      cnt++;
        end
    endtask

    int cyc = 0;

    task automatic tick();
        logic [8:0] ea, eb;
        #4;
        ea = expect_out(mode_a);
        eb = expect_out(mode_b);
        check($sformatf("t64_c%0d", cyc), {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, st_a, bz_a, er_a}, ea);
        check($sformatf("t4_c%0d", cyc),  {sf_b, sd_b, se_b, fd_b, fe_b, fm_b, st_b, bz_b, er_b}, eb);
        @(posedge clk);
        advance(mode_a, cnt_a, 64);
        advance(mode_b, cnt_b, 4);
        cyc++;
        #1;
    endtask

    task automatic quiet();
        rst = 0; Rs1_D = 0; Rs2_D = 0; RD_E = 0; RegWriteE = 0; ResultSrcE0 = 0;
        PCSrcE = 0; MulDivE = 0; MD_Done = 0;
    endtask

    initial begin
        mode_a = 0; cnt_a = 0; mode_b = 0; cnt_b = 0;
        quiet();
        rst = 1;
        repeat (3) tick();
        quiet();
        tick();
        check("reset_idle", {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, st_a, bz_a, er_a}, 9'd0);

        // load-use on Rs2, then the same with x0 as destination
        ResultSrcE0 = 1; RegWriteE = 1; RD_E = 5; Rs2_D = 5; Rs1_D = 7;
        tick();
        quiet(); tick();
        ResultSrcE0 = 1; RegWriteE = 1; RD_E = 0; Rs2_D = 0;
        tick();
        quiet();

        // taken branch
        PCSrcE = 1; tick();
        PCSrcE = 0; tick();

        // mul/div, done at cycle 6, with a branch + load-use during RUN
        MulDivE = 1; tick();
        MulDivE = 0;
        for (int i = 1; i <= 6; i++) begin
            PCSrcE = (i == 3); ResultSrcE0 = (i == 3); RegWriteE = (i == 3);
            RD_E = 5'd3; Rs1_D = 5'd3;
            MD_Done = (i == 6);
            tick();
        end
        quiet(); tick();
        MD_Done = 1; tick();            // spurious MD_Done in IDLE
        quiet();

        // back-to-back mul/div with no dead cycle
        MulDivE = 1; tick();
        MulDivE = 0; tick(); MD_Done = 1; MulDivE = 1; tick();
        MD_Done = 0; tick();
        MulDivE = 0; MD_Done = 1; tick();
        quiet();

        // MulDivE together with PCSrcE: branch wins
        MulDivE = 1; PCSrcE = 1; tick();
        quiet();

        // timeout, then a one-cycle reset
        rst = 1; tick(); quiet();
        MulDivE = 1; tick(); MulDivE = 0;
        repeat (9) tick();
        rst = 1; tick(); rst = 0; tick();

        // reset mid-RUN
        MulDivE = 1; tick(); MulDivE = 0;
        repeat (2) tick();
        rst = 1; tick(); rst = 0;
        repeat (2) tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 29) == 0);
            MulDivE     = ($urandom_range(0, 3) == 0);
            PCSrcE      = ($urandom_range(0, 4) == 0);
            MD_Done     = ($urandom_range(0, 3) == 0);
            ResultSrcE0 = ($urandom_range(0, 1) == 0);
            RegWriteE   = ($urandom_range(0, 3) != 0);
            RD_E        = 5'($urandom_range(0, 3));
            Rs1_D       = 5'($urandom_range(0, 3));
            Rs2_D       = 5'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequences the 5-stage RISC-V pipeline by generating stall and flush controls for the F, D, E and M stage registers.
- Covers three hazard sources:
  - load-use hazards, which need a 1-cycle bubble;
  - taken branches and jumps resolved in E;
  - multi-cycle mul/div operations held in E until the mul/div unit returns MD_Done.
- Sits beside the forwarding unit. Forwarding handles the remaining RAW cases.

Parameters:
- MD_TIMEOUT, default 64: maximum cycles in RUN before a missing MD_Done is declared an error.
- REG_AW, default 5: register-address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- Rs1_D  in  REG_AW  source register 1 of the D-stage instruction
- Rs2_D  in  REG_AW  source register 2 of the D-stage instruction
- RD_E  in  REG_AW  destination of the E-stage instruction
- RegWriteE  in  1  E-stage instruction writes the register file
- ResultSrcE0  in  1  E-stage instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in E
- MulDivE  in  1  E-stage instruction is a multi-cycle mul/div
- MD_Done  in  1  single-cycle pulse: mul/div result valid
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register (bubble)
- FlushM  out  1  clear EX/MEM register (bubble)
- MD_Start  out  1  single-cycle launch pulse to the mul/div unit
- MD_Busy  out  1  FSM in RUN
- MD_TimeoutErr  out  1  sticky error flag

Behaviour:
- While rst=1, all outputs are 0. At the next rising edge the FSM goes to IDLE, the counter clears to 0 and MD_TimeoutErr clears.
- Load-use detect (combinational):
  - lw_stall = ResultSrcE0 & RegWriteE & (RD_E != 0) & (RD_E == Rs1_D | RD_E == Rs2_D).
- FSM states: IDLE, RUN, ERR. Counter cnt has width $clog2(MD_TIMEOUT+1).
- IDLE:
  - If MulDivE=1: MD_Start=1, StallF=StallD=StallE=1, FlushM=1. Next state RUN, cnt<=0.
  - Otherwise: StallF=StallD=lw_stall, FlushE=lw_stall|PCSrcE, FlushD=PCSrcE, all other outputs 0.
  - MulDivE with PCSrcE in the same cycle is illegal encoding. PCSrcE wins: no MD_Start, and branch flush behaviour applies.
  - MD_Done in IDLE is ignored.
- RUN:
  - MD_Busy=1. StallF=StallD=StallE=1 and FlushM=1 every cycle.
  - FlushD and FlushE are forced 0, so lw_stall and PCSrcE are ignored and the held mul/div is never killed.
  - If MD_Done=1: stalls and FlushM drop in that same cycle, the instruction advances at the edge, next state IDLE.
  - Else if cnt == MD_TIMEOUT-1: next state ERR.
  - Else cnt <= cnt+1.
- ERR:
  - MD_TimeoutErr=1. StallF=StallD=StallE=1 and FlushM=1, held until rst.
  - MD_Done is ignored.
- Latency:
  - Load-use costs exactly 1 bubble cycle.
  - Taken branch flushes D and E in the resolve cycle.
  - A mul/div occupies E for (cycles until MD_Done)+1.
- Back-to-back mul/div: after MD_Done, if the next instruction entering E also has MulDivE, IDLE launches it with a fresh MD_Start. No dead cycle is required.
- Reset asserted mid-RUN abandons the operation. No MD_Start is reissued.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - md_state_t enum {IDLE, RUN, ERR};
  - REG_AW default;
  - localparam X0 = 5'd0.
- One sub-module, md_seq_fsm, contains the FSM, the timeout counter and the sticky error.
  - Inputs: MulDivE, PCSrcE, MD_Done.
  - Outputs: md_hold, MD_Start, MD_Busy, MD_TimeoutErr.
  - The top level merges md_hold with lw_stall and branch logic per the priority above.

Test Plan:
- Load-use: ResultSrcE0=1, RegWriteE=1, RD_E=5, Rs2_D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Repeat with RD_E=0 -> all 0.
- Taken branch: PCSrcE=1, no load -> FlushD=FlushE=1 for 1 cycle, stalls 0.
- Mul/div: MulDivE=1 at cycle 0, MD_Done at cycle 6 -> MD_Start pulse at cycle 0, MD_Busy cycles 1-6, stalls and FlushM cycles 0-5, all 0 at cycle 6. Next cycle with MulDivE=0 -> idle outputs.
- Suppression: during RUN, drive PCSrcE=1 plus a matching load-use -> FlushD=FlushE=0. Spurious MD_Done in IDLE -> no effect.
- Timeout: MD_TIMEOUT=4, no MD_Done -> ERR entered 4 cycles after the RUN entry edge, MD_TimeoutErr=1 and stalls held. Assert rst 1 cycle -> all outputs 0, state IDLE.
- Reset mid-RUN at cycle 3 -> the cycle after reset has MD_Busy=0, cnt=0, and no MD_Start unless MulDivE is re-presented.
